// File: rtl/vlc_pkg.sv
// Shared definitions for the VLC decoders (AC run, AC level, DC):
// window width, context reset value, run codebook type, the run-codebook
// lookup, and the decoder FSM state encoding.
package vlc_pkg;

    localparam int         WIN_W             = 32;
    localparam logic [3:0] PREV_INIT_DEFAULT = 4'd4;

    // Adaptive Golomb codebook: Rice parameter, Exp-Golomb order and the
    // quotient value at which the code switches from Rice to Exp-Golomb.
    typedef struct packed {
        logic [1:0] rice_k;
        logic [1:0] exp_k;
        logic [1:0] sw;
    } codebook_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EMIT
    } dec_state_t;

    // Run codebook selected by the previously decoded (saturated) run.
    function automatic codebook_t run_codebook(input logic [3:0] prev_run);
        codebook_t cb;
        if (prev_run <= 4'd1)       cb = '{rice_k: 2'd0, exp_k: 2'd1, sw: 2'd2};
        else if (prev_run <= 4'd3)  cb = '{rice_k: 2'd0, exp_k: 2'd1, sw: 2'd1};
        else if (prev_run == 4'd4)  cb = '{rice_k: 2'd0, exp_k: 2'd1, sw: 2'd0};
        else if (prev_run <= 4'd8)  cb = '{rice_k: 2'd1, exp_k: 2'd2, sw: 2'd1};
        else if (prev_run <= 4'd14) cb = '{rice_k: 2'd1, exp_k: 2'd2, sw: 2'd0};
        else                        cb = '{rice_k: 2'd2, exp_k: 2'd3, sw: 2'd0};
        return cb;
    endfunction

endpackage

// File: rtl/golomb_combo_decode.sv
// Combinational adaptive Rice/Exp-Golomb codeword decoder.
// Given an MSB-first bit window and a codebook, returns the decoded value,
// the number of bits the codeword occupies and a malformed-codeword flag.
// Malformed codewords (no terminating one, or longer than the window)
// decode to value 0 with length 32 so downstream logic sees a saturated
// result. Shared by the AC run, AC level and DC decoders.
module golomb_combo_decode
    import vlc_pkg::*;
(
    input  logic [WIN_W-1:0] bits,
    input  codebook_t        cb,
    output logic [WIN_W-1:0] run,
    output logic [5:0]       length,
    output logic             err
);

    logic [5:0]       q;
    logic             rice_sel;
    logic [WIN_W-1:0] rice_rem;
    logic [WIN_W-1:0] rice_run;
    logic [5:0]       rice_len;
    logic [6:0]       eg_len;
    logic [WIN_W-1:0] eg_val;
    logic [WIN_W-1:0] eg_run;

    // Leading-zero count: later iterations overwrite, so the highest set bit wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        q = 6'd32;
        for (int i = 0; i < WIN_W; i++) begin
            if (bits[i]) q = 6'(WIN_W - 1 - i);
        end
    end

    // Evaluate both code branches in parallel; the codebook picks one below.
    always_comb begin
        rice_sel = (q <= {4'd0, cb.sw});
        // Remainder sits right after the terminating one; rice_k==0 shifts it all out.
        rice_rem = (bits << (q + 6'd1)) >> (6'd32 - {4'd0, cb.rice_k});
        rice_run = ({26'd0, q} << cb.rice_k) | rice_rem;
        rice_len = q + 6'd1 + {4'd0, cb.rice_k};
        eg_len   = {q, 1'b0} + {5'd0, cb.exp_k} - {5'd0, cb.sw};
        eg_val   = bits >> (7'd32 - eg_len);
        eg_run   = eg_val - (32'd1 << cb.exp_k)
                 + (({30'd0, cb.sw} + 32'd1) << cb.rice_k);
    end

    // Branch select with saturation of malformed codewords.
    always_comb begin
        err    = (q == 6'd32) || (!rice_sel && (eg_len > 7'd32));
        run    = '0;
        length = 6'd32;
        if (!err) begin
            if (rice_sel) begin
                run    = rice_run;
                length = rice_len;
            end else begin
                run    = eg_run;
                length = eg_len[5:0];
            end
        end
    end

endmodule

// File: rtl/entropy_decode_ac_run_coefficients.sv
// AC zero-run VLC decoder. Accepts a 32-bit peek window positioned at a run
// codeword, decodes it with the codebook chosen by the previous run, and
// returns the run and the number of bits consumed. One codeword in flight:
// the next window is only accepted after the result handshake, because the
// context for the next codeword is the run just decoded.
// Optional build macro AC_RUN_DEC_ERROR_CHECK_EN: when defined, out_error
// flags malformed codewords; otherwise out_error is tied low.
module entropy_decode_ac_run_coefficients
    import vlc_pkg::*;
#(
    parameter int RUN_W     = 32,
    parameter int PREV_INIT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             block_start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_bits,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RUN_W-1:0] out_run,
    output logic [5:0]       out_length,
    output logic             out_error
);

    localparam logic [3:0] PREV_INIT_V = 4'(PREV_INIT);

    dec_state_t       state;
    logic [WIN_W-1:0] win_q;
    codebook_t        cb_q;
    logic [3:0]       prev_run;
    logic             err_q;

    logic [WIN_W-1:0] dec_run;
    logic [5:0]       dec_len;
    logic             dec_err;

    golomb_combo_decode u_golomb (
        .bits   (win_q),
        .cb     (cb_q),
        .run    (dec_run),
        .length (dec_len),
        .err    (dec_err)
    );

    // Control FSM, window/codebook capture, result registers and run context.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            state      <= ST_IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_run    <= '0;
            out_length <= 6'd0;
            win_q      <= '0;
            cb_q       <= run_codebook(PREV_INIT_V);
            err_q      <= 1'b0;
            prev_run   <= PREV_INIT_V;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        win_q    <= in_bits;
                        // A block start on the accept cycle already applies to this codeword.
                        cb_q     <= run_codebook(block_start ? PREV_INIT_V : prev_run);
                        err_q    <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    out_run    <= RUN_W'(dec_run);
                    out_length <= dec_len;
                    err_q      <= dec_err;
                    out_valid  <= 1'b1;
                    state      <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                        // Malformed codewords leave the context untouched.
                        if (!err_q) begin
                            prev_run <= (out_run > RUN_W'(15)) ? 4'd15 : out_run[3:0];
                        end
                    end
                end
                default: begin
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
            // NOTE: placed last so it overrides the handshake context update in the same cycle.
            if (block_start) prev_run <= PREV_INIT_V;
        end
    end

`ifdef AC_RUN_DEC_ERROR_CHECK_EN
    // Error flag is set with the result and held until the next accept.
    assign out_error = err_q;
`else
    assign out_error = 1'b0;
`endif

endmodule

// File: tb/tb_entropy_decode_ac_run_coefficients.sv
// Self-checking bench for entropy_decode_ac_run_coefficients.
// Expected results come from an encoder-side model: runs are encoded into
// bit windows with the run codebook and the decoder must return the same
// run and code length. Directed windows with hand-computed results cover
// the boundary cases and pin the encoder model itself.
module tb_entropy_decode_ac_run_coefficients;

`ifdef AC_RUN_DEC_ERROR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        block_start;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_bits;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_run;
    logic [5:0]  out_length;
    logic        out_error;

    entropy_decode_ac_run_coefficients #(.RUN_W(32), .PREV_INIT(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .block_start (block_start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_bits     (in_bits),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_run     (out_run),
        .out_length  (out_length),
        .out_error   (out_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int model_prev = 4;

    typedef struct {
        int unsigned run;
        int          len;
        bit          err;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Codebook table, straight from the run-context ranges.
    task automatic codebook(input int ctx, output int rk, output int ek, output int sw);
        if (ctx <= 1)       begin rk = 0; ek = 1; sw = 2; end
        else if (ctx <= 3)  begin rk = 0; ek = 1; sw = 1; end
        else if (ctx == 4)  begin rk = 0; ek = 1; sw = 0; end
        else if (ctx <= 8)  begin rk = 1; ek = 2; sw = 1; end
        else if (ctx <= 14) begin rk = 1; ek = 2; sw = 0; end
        else                begin rk = 2; ek = 3; sw = 0; end
    endtask

    // Encoder model: run -> left-aligned codeword and its length.
    task automatic encode(input int unsigned run, input int ctx,
                          output logic [31:0] bits, output int len);
        int rk, ek, sw, q, nb;
        int unsigned thr, v;
        logic [63:0] code;
        codebook(ctx, rk, ek, sw);
        thr = (sw + 1) << rk;
        if (run < thr) begin
            q    = run >> rk;
            len  = q + 1 + rk;
            code = 64'((1 << rk) | (run & ((1 << rk) - 1)));
        end else begin
            v    = run - thr + (1 << ek);
            nb   = $clog2(v + 1);
            q    = nb - ek + sw;
            len  = q + nb;
            code = 64'(v);
        end
        code = code << (32 - len);
        bits = code[31:0];
    endtask

    // Result checker: every cycle out_valid is high the outputs must match the oldest pending result.
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
        end else if (out_valid) begin
            check("valid_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                check("out_run", 64'(out_run), 64'(exp_q[0].run));
                check("out_length", 64'(out_length), 64'(exp_q[0].len));
                check("out_error", 64'(out_error), 64'(ERR_EN && exp_q[0].err));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // One full transaction: accept, latency, optional stall, handshake.
    task automatic xact(input logic [31:0] bits, input logic bs, input int stall,
                        input logic bs_hs, input int unsigned erun, input int elen,
                        input logic eerr);
        exp_t e;
        in_bits     = bits;
        in_valid    = 1'b1;
        block_start = bs;
        check("in_ready_idle", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid    = 1'b0;
        block_start = 1'b0;
        if (bs) model_prev = 4;
        e.run = erun; e.len = elen; e.err = eerr;
        exp_q.push_back(e);
        check("decode_no_valid", 64'(out_valid), 64'd0);
        check("decode_in_ready", 64'(in_ready), 64'd0);
        check("error_cleared", 64'(out_error), 64'd0);
        @(posedge clk); #1;
        check("latency_emit", 64'(out_valid), 64'd1);
        if (out_valid !== 1'b1) begin
            for (int i = 0; i < 8 && out_valid !== 1'b1; i++) begin
                @(posedge clk); #1;
            end
            if (out_valid !== 1'b1) begin
                check("emit_timeout", 64'(out_valid), 64'd1);
                return;
            end
        end
        for (int i = 0; i < stall; i++) begin
            out_ready = 1'b0;
            @(posedge clk); #1;
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready   = 1'b1;
        block_start = bs_hs;
        @(posedge clk); #1;
        out_ready   = 1'b0;
        block_start = 1'b0;
        if (bs_hs)      model_prev = 4;
        else if (!eerr) model_prev = (erun > 15) ? 15 : int'(erun);
        check("hs_valid_low", 64'(out_valid), 64'd0);
        check("hs_in_ready", 64'(in_ready), 64'd1);
        check("hold_run", 64'(out_run), 64'(erun));
        check("hold_length", 64'(out_length), 64'(elen));
    endtask

    // Encode a run in the current model context, pad with random tail bits, decode it.
    task automatic xact_run(input int unsigned run, input logic bs, input int stall, input logic bs_hs);
        logic [31:0] bits, mask;
        int len;
        encode(run, bs ? 4 : model_prev, bits, len);
        mask = (len >= 32) ? 32'd0 : (32'hFFFF_FFFF >> len);
        bits = bits | ($urandom() & mask);
        xact(bits, bs, stall, bs_hs, run, len, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] mb;
        int          ml;
        int unsigned r;

        reset_n = 1'b0; block_start = 1'b0; in_valid = 1'b0; in_bits = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_run", 64'(out_run), 64'd0);
        check("rst_out_length", 64'(out_length), 64'd0);
        check("rst_out_error", 64'(out_error), 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Pin the encoder model against hand-derived codewords.
        encode(0, 4, mb, ml);     check("model_r0_c4", {mb, 32'(ml)}, {32'h8000_0000, 32'd1});
        encode(2, 4, mb, ml);     check("model_r2_c4", {mb, 32'(ml)}, {32'h6000_0000, 32'd3});
        encode(2, 0, mb, ml);     check("model_r2_c0", {mb, 32'(ml)}, {32'h2000_0000, 32'd3});
        encode(4, 2, mb, ml);     check("model_r4_c2", {mb, 32'(ml)}, {32'h1000_0000, 32'd6});
        encode(3, 15, mb, ml);    check("model_r3_c15", {mb, 32'(ml)}, {32'hE000_0000, 32'd3});
        encode(32768, 2, mb, ml); check("model_len32", {mb, 32'(ml)}, {32'h0000_8000, 32'd32});

        // Basic decodes across the context chain 4 -> 0 -> 2 -> 4 -> 2.
        xact(32'h8000_0000, 1'b0, 0, 1'b0, 0, 1, 1'b0);
        xact(32'h2000_0000, 1'b0, 0, 1'b0, 2, 3, 1'b0);
        xact(32'h1000_0000, 1'b0, 0, 1'b0, 4, 6, 1'b0);
        xact(32'h6000_0000, 1'b0, 0, 1'b0, 2, 3, 1'b0);

        // Saturated context, then block_start bypass on accept.
        xact_run(100, 1'b0, 0, 1'b0);
        xact(32'hE000_0000, 1'b0, 0, 1'b0, 3, 3, 1'b0);
        xact(32'h6000_0000, 1'b1, 0, 1'b0, 2, 3, 1'b0);
        xact(32'h8000_0000, 1'b1, 0, 1'b0, 0, 1, 1'b0);

        // Back-pressure with block_start winning on the handshake cycle.
        xact(32'h8000_0000, 1'b0, 3, 1'b1, 0, 1, 1'b0);
        xact(32'h6000_0000, 1'b0, 0, 1'b0, 2, 3, 1'b0);

        // Malformed codewords leave the context alone; exact 32-bit codeword is legal.
        xact(32'h0000_0000, 1'b0, 1, 1'b0, 0, 32, 1'b1);
        xact(32'h2000_0000, 1'b0, 0, 1'b0, 2, 4, 1'b0);
        xact(32'h0000_8000, 1'b0, 0, 1'b0, 32768, 32, 1'b0);
        xact(32'h0000_8000, 1'b0, 0, 1'b0, 0, 32, 1'b1);
        xact(32'hE000_0000, 1'b0, 0, 1'b0, 3, 3, 1'b0);

        // Reset while the result is being emitted drops it and restores the context.
        in_bits = 32'h8000_0000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_reset_valid", 64'(out_valid), 64'd1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_prev = 4;
        check("reset_emit_valid", 64'(out_valid), 64'd0);
        check("reset_emit_ready", 64'(in_ready), 64'd1);
        check("reset_emit_run", 64'(out_run), 64'd0);
        xact(32'h6000_0000, 1'b0, 0, 1'b0, 2, 3, 1'b0);

        // Random run stream round trip.
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0:       r = $urandom_range(0, 3);
                1:       r = $urandom_range(0, 20);
                2:       r = $urandom_range(0, 300);
                default: r = $urandom_range(0, 20000);
            endcase
            xact_run(r, ($urandom_range(0, 7) == 0), $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0,
                     ($urandom_range(0, 9) == 0));
        end

        repeat (2) @(posedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
